// File: rtl/tabajara_pkg.sv
// Shared screen geometry, colours and shot FSM encoding for the projectile blocks.
package tabajara_pkg;

    localparam int unsigned Y_TOP    = 3;
    localparam int unsigned X_LEFT   = 97;
    localparam int unsigned Y_BOTTOM = 540;

    localparam int unsigned COORD_W = 11;
    localparam int unsigned SCAN_W  = 10;
    localparam int unsigned COLOR_W = 8;

    typedef struct packed {
        logic [COLOR_W-1:0] r;
        logic [COLOR_W-1:0] g;
        logic [COLOR_W-1:0] b;
    } rgb_t;

    localparam rgb_t RGB_BLACK = '{r: 8'd0, g: 8'd0,   b: 8'd0};
    localparam rgb_t RGB_GREEN = '{r: 8'd0, g: 8'd255, b: 8'd0};

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FLIGHT   = 2'd1,
        ST_COOLDOWN = 2'd2
    } shot_state_e;

endpackage

// File: rtl/municao_jogador_if.sv
// Game-side bus of the player shot: ship/enemy positions and scan counters in, shot state and pixel out.
interface municao_jogador_if;
    import tabajara_pkg::*;

    logic [COORD_W-1:0] posX_nave;
    logic [COORD_W-1:0] posY_nave;
    logic [COORD_W-1:0] posX_inimigo;
    logic [COORD_W-1:0] posY_inimigo;
    logic [SCAN_W-1:0]  h_counter;
    logic [SCAN_W-1:0]  v_counter;
    logic [COORD_W-1:0] posX_Municao;
    logic [COORD_W-1:0] posY_Municao;
    logic               tiro_ativo;
    logic               acerto;
    logic [COLOR_W-1:0] R;
    logic [COLOR_W-1:0] G;
    logic [COLOR_W-1:0] B;

    modport master (
        output posX_nave, posY_nave, posX_inimigo, posY_inimigo, h_counter, v_counter,
        input  posX_Municao, posY_Municao, tiro_ativo, acerto, R, G, B
    );

    modport slave (
        input  posX_nave, posY_nave, posX_inimigo, posY_inimigo, h_counter, v_counter,
        output posX_Municao, posY_Municao, tiro_ativo, acerto, R, G, B
    );

endinterface

// File: rtl/botao_borda.sv
// Two-flop synchronizer for a raw push button followed by a registered rising-edge pulse.
module botao_borda (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic pulse
);

    logic sync1_q;
    logic sync2_q;
    logic last_q;
    logic pulse_q;
    logic pulse_d;

    always_comb begin
        pulse_d = sync2_q & ~last_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            last_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
            last_q  <= sync2_q;
            pulse_q <= pulse_d;
        end
    end

    assign pulse = pulse_q;

endmodule

// File: rtl/municao_jogador.sv
// Player shot: launches from the ship on a fire edge, climbs, hit-tests the enemy box and renders itself.
// Optional MUNICAO_COOLDOWN_EN stretches the post-shot lockout to COOLDOWN_TICKS clocks.
module municao_jogador
    import tabajara_pkg::*;
#(
    parameter int unsigned MOVE_DELAY     = 500000,
    parameter int unsigned SHOT_LEN       = 20,
    parameter int unsigned ENEMY_W        = 40,
    parameter int unsigned ENEMY_H        = 40,
    parameter int unsigned COOLDOWN_TICKS = 25000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btn_fire,
    municao_jogador_if.slave bus
);

    localparam int unsigned EXT_W  = COORD_W + 1;
    localparam int unsigned STEP_W = $clog2(MOVE_DELAY + 1);
    localparam int unsigned CD_W   = $clog2(COOLDOWN_TICKS + 1);
`ifdef MUNICAO_COOLDOWN_EN
    localparam int unsigned CD_LEN = COOLDOWN_TICKS;
`else
    localparam int unsigned CD_LEN = 1;
`endif

    logic fire_c;

    botao_borda u_fire (
        .clk   (clk),
        .rst_n (reset),
        .btn   (btn_fire),
        .pulse (fire_c)
    );

    shot_state_e        state_q, state_d;
    logic [COORD_W-1:0] x_q, x_d;
    logic [COORD_W-1:0] y_q, y_d;
    logic [STEP_W-1:0]  step_q, step_d;
    logic [CD_W-1:0]    cd_q, cd_d;
    logic               tiro_q, tiro_d;
    logic               acerto_q, acerto_d;
    logic [COORD_W-1:0] pos_x_q, pos_x_d;
    logic [COORD_W-1:0] pos_y_q, pos_y_d;
    rgb_t               rgb_q, rgb_d;

    logic [EXT_W-1:0] enemy_x_end_c;
    logic [EXT_W-1:0] enemy_y_end_c;
    logic [EXT_W-1:0] shot_y_end_c;
    logic             hit_c;
    logic             step_last_c;
    logic             visible_c;

    // Enemy box and shot extent use one extra bit so right/bottom edges never wrap.
    always_comb begin
        enemy_x_end_c = EXT_W'(bus.posX_inimigo) + EXT_W'(ENEMY_W);
        enemy_y_end_c = EXT_W'(bus.posY_inimigo) + EXT_W'(ENEMY_H);
        shot_y_end_c  = EXT_W'(y_q) + EXT_W'(SHOT_LEN);
        hit_c = (x_q >= bus.posX_inimigo) && (EXT_W'(x_q) < enemy_x_end_c) &&
                (y_q >= bus.posY_inimigo) && (EXT_W'(y_q) < enemy_y_end_c);
        step_last_c = (step_q == STEP_W'(MOVE_DELAY - 1));
        visible_c   = (bus.v_counter > SCAN_W'(Y_TOP - 1)) && (bus.h_counter >= SCAN_W'(X_LEFT));
    end

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        step_d   = step_q;
        cd_d     = cd_q;
        acerto_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (fire_c && (bus.posY_nave > COORD_W'(Y_TOP))) begin
                    x_d     = bus.posX_nave;
                    y_d     = bus.posY_nave - COORD_W'(1);
                    step_d  = '0;
                    state_d = ST_FLIGHT;
                end
            end
            ST_FLIGHT: begin
                // A hit wins over a step landing in the same cycle.
                if (hit_c) begin
                    acerto_d = 1'b1;
                    cd_d     = '0;
                    state_d  = ST_COOLDOWN;
                end else if (step_last_c) begin
                    step_d = '0;
                    if (y_q <= COORD_W'(Y_TOP)) begin
                        cd_d    = '0;
                        state_d = ST_COOLDOWN;
                    end else begin
                        y_d = y_q - COORD_W'(1);
                    end
                end else begin
                    step_d = step_q + STEP_W'(1);
                end
            end
            ST_COOLDOWN: begin
                if (cd_q == CD_W'(CD_LEN - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    cd_d = cd_q + CD_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        tiro_d  = (state_d == ST_FLIGHT);
        pos_x_d = x_q;
        pos_y_d = y_q;

        rgb_d = RGB_BLACK;
        if (visible_c && tiro_q && (COORD_W'(bus.h_counter) == x_q) &&
            (EXT_W'(bus.v_counter) >= EXT_W'(y_q)) && (EXT_W'(bus.v_counter) < shot_y_end_c)) begin
            rgb_d = RGB_GREEN;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            x_q      <= '0;
            y_q      <= '0;
            step_q   <= '0;
            cd_q     <= '0;
            tiro_q   <= 1'b0;
            acerto_q <= 1'b0;
            pos_x_q  <= '0;
            pos_y_q  <= '0;
            rgb_q    <= RGB_BLACK;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            step_q   <= step_d;
            cd_q     <= cd_d;
            tiro_q   <= tiro_d;
            acerto_q <= acerto_d;
            pos_x_q  <= pos_x_d;
            pos_y_q  <= pos_y_d;
            rgb_q    <= rgb_d;
        end
    end

    assign bus.tiro_ativo   = tiro_q;
    assign bus.acerto       = acerto_q;
    assign bus.posX_Municao = pos_x_q;
    assign bus.posY_Municao = pos_y_q;
    assign bus.R            = rgb_q.r;
    assign bus.G            = rgb_q.g;
    assign bus.B            = rgb_q.b;

endmodule

// File: tb/tb_municao_jogador.sv
// Bench for municao_jogador: directed scenarios plus random play against a cycle-level shot model.
module tb_municao_jogador;

    localparam int MD     = 4;
    localparam int SL     = 4;
    localparam int EW     = 10;
    localparam int EH     = 10;
    localparam int YT     = 3;
    localparam int XL     = 97;
`ifdef MUNICAO_COOLDOWN_EN
    localparam int CD_LEN = 8;
`else
    localparam int CD_LEN = 1;
`endif

    logic clk = 1'b0;
    logic reset;
    logic btn_fire;

    municao_jogador_if bus ();

    municao_jogador #(
        .MOVE_DELAY     (MD),
        .SHOT_LEN       (SL),
        .ENEMY_W        (EW),
        .ENEMY_H        (EH),
        .COOLDOWN_TICKS (8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .btn_fire (btn_fire),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: shot height follows from launch row and age; 0 idle, 1 flight, 2 cooldown.
    int m_st, m_x, m_y0, m_age, m_cd;
    int e_tiro, e_acerto, e_px, e_py, e_r, e_g, e_b;
    bit btn_hist[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_x = 0; m_y0 = 0; m_age = 0; m_cd = 0;
        e_tiro = 0; e_acerto = 0; e_px = 0; e_py = 0; e_r = 0; e_g = 0; e_b = 0;
        btn_hist = '{0, 0, 0, 0, 0};
    endtask

    task automatic model_update();
        int  y, h, v, ex, ey;
        bit  fire, hit;
        fire = btn_hist[2] && !btn_hist[3];
        btn_hist.push_front(btn_fire);
        void'(btn_hist.pop_back());
        y  = m_y0 - m_age / MD;
        h  = int'(bus.h_counter);
        v  = int'(bus.v_counter);
        ex = int'(bus.posX_inimigo);
        ey = int'(bus.posY_inimigo);
        hit = (m_st == 1) && (m_x >= ex) && (m_x < ex + EW) && (y >= ey) && (y < ey + EH);
        e_r = 0; e_g = 0; e_b = 0;
        if (v >= YT && h >= XL && m_st == 1 && h == m_x && v >= y && v < y + SL) e_g = 255;
        e_px = m_x;
        e_py = y;
        e_acerto = hit ? 1 : 0;
        case (m_st)
            0: if (fire && int'(bus.posY_nave) > YT) begin
                   m_x = int'(bus.posX_nave); m_y0 = int'(bus.posY_nave) - 1; m_age = 0; m_st = 1;
               end
            1: if (hit) begin
                   m_st = 2; m_cd = CD_LEN;
               end else if ((m_age + 1) % MD == 0 && y - 1 < YT) begin
                   m_st = 2; m_cd = CD_LEN;
               end else begin
                   m_age++;
               end
            default: begin
                m_cd--;
                if (m_cd == 0) m_st = 0;
            end
        endcase
        e_tiro = (m_st == 1) ? 1 : 0;
    endtask

    task automatic check_outputs();
        chk("tiro_ativo",   bus.tiro_ativo,   e_tiro);
        chk("acerto",       bus.acerto,       e_acerto);
        chk("posX_Municao", bus.posX_Municao, e_px);
        chk("posY_Municao", bus.posY_Municao, e_py);
        chk("R",            bus.R,            e_r);
        chk("G",            bus.G,            e_g);
        chk("B",            bus.B,            e_b);
    endtask

    task automatic tick();
        @(posedge clk);
        if (!reset) model_reset(); else model_update();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic press();
        btn_fire = 1'b1;
        repeat (3) tick();
        btn_fire = 1'b0;
        tick();
    endtask

    task automatic wait_tiro(input logic val, input int budget, input string tag);
        int n = 0;
        while (bus.tiro_ativo !== val && n < budget) begin tick(); n++; end
        chk(tag, bus.tiro_ativo, val);
    endtask

    task automatic set_ship(input int x, input int y);
        bus.posX_nave = 11'(x); bus.posY_nave = 11'(y);
    endtask

    task automatic set_enemy(input int x, input int y);
        bus.posX_inimigo = 11'(x); bus.posY_inimigo = 11'(y);
    endtask

    initial begin
        int n, seen;
        reset = 1'b0; btn_fire = 1'b0;
        set_ship(0, 0); set_enemy(1000, 1000);
        bus.h_counter = '0; bus.v_counter = '0;
        model_reset();
        repeat (3) tick();
        reset = 1'b1;
        repeat (20) tick();
        chk("idle_no_press", bus.tiro_ativo, 0);

        // Launch from (200,400); shot then walks up one row per MD clocks.
        set_ship(200, 400);
        press();
        wait_tiro(1'b1, 10, "launch");
        tick();
        chk("first_y", bus.posY_Municao, 399);
        chk("first_x", bus.posX_Municao, 200);
        repeat (MD) tick();
        chk("step_y", bus.posY_Municao, 398);

        // Fire during flight is ignored; enemy placed so the shot hits at row 389.
        press();
        set_enemy(195, 380);
        n = 0;
        while (bus.acerto !== 1'b1 && n < 100) begin tick(); n++; end
        chk("hit_seen", bus.acerto, 1);
        chk("hit_y", bus.posY_Municao, 389);
        chk("hit_tiro_off", bus.tiro_ativo, 0);
        tick();
        chk("hit_pulse_len", bus.acerto, 0);
        repeat (CD_LEN + 2) tick();
        chk("no_relaunch", bus.tiro_ativo, 0);

        // Shot runs off the top with no enemy in its column.
        set_enemy(600, 600);
        set_ship(150, 10);
        press();
        wait_tiro(1'b1, 10, "launch_top");
        seen = 0; n = 0;
        while (bus.tiro_ativo === 1'b1 && n < 100) begin
            tick(); n++;
            if (bus.acerto === 1'b1) seen++;
        end
        chk("top_died", bus.tiro_ativo, 0);
        chk("top_no_hit", seen, 0);
        chk("top_y", bus.posY_Municao, 3);
        repeat (CD_LEN + 2) tick();

        // Ship at or above the top line: press is dropped.
        set_ship(150, 3);
        press();
        repeat (4) tick();
        chk("top_ship_drop", bus.tiro_ativo, 0);

        // Render: shot at X=200, Y=300.
        set_ship(200, 301);
        press();
        wait_tiro(1'b1, 10, "launch_render");
        bus.h_counter = 10'd200; bus.v_counter = 10'd301;
        tick();
        chk("pix_green", bus.G, 255);
        bus.v_counter = 10'd304;
        tick();
        chk("pix_below_black", bus.G, 0);

        // Async reset mid-flight clears everything at once.
        reset = 1'b0;
        #1;
        chk("rst_tiro", bus.tiro_ativo, 0);
        chk("rst_posY", bus.posY_Municao, 0);
        chk("rst_posX", bus.posX_Municao, 0);
        chk("rst_acerto", bus.acerto, 0);
        model_reset();
        tick();
        reset = 1'b1;
        tick();

        // Left blank region: shot at X=90 is never drawn.
        set_ship(90, 320);
        press();
        wait_tiro(1'b1, 10, "launch_left");
        bus.h_counter = 10'd90; bus.v_counter = 10'd320;
        tick();
        chk("pix_left_black", bus.G, 0);
        wait_tiro(1'b0, 2000, "left_end");
        repeat (CD_LEN + 2) tick();

        // Random play.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) btn_fire = ~btn_fire;
            if ($urandom_range(0, 40) == 0)
                set_ship(int'($urandom_range(90, 220)),
                         ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 8)) : int'($urandom_range(20, 120)));
            if ($urandom_range(0, 60) == 0)
                set_enemy(int'(bus.posX_nave) - int'($urandom_range(0, 12)), int'($urandom_range(0, 100)));
            bus.h_counter = ($urandom_range(0, 1) == 0) ? 10'(m_x) : 10'($urandom_range(80, 230));
            bus.v_counter = 10'($urandom_range(0, 130));
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
